// File: rtl/race_sequencer.sv
// race_sequencer
//
// Frame-rate race flow controller sitting between the keyboard/collision
// logic and the player controller. Owns the race state machine together with
// the lives, fuel and distance scoreboard values. Every register advances only
// on clock edges where frame_start is high.
//
// Optional feature macro: PAUSE_EN
//   When defined, a pause_key input is added. A pause key edge in RACING
//   freezes the race in PAUSED (game_state 6), and a second edge resumes it.
//   When undefined, there is no pause_key port and game_state never reads 6.
//
// Ports
//   clk             system clock
//   reset           synchronous active-high reset; wins over frame_start
//   frame_start     one-cycle pulse per video frame
//   start_key       start/restart key level (edge detected per frame)
//   pause_key       pause key level (PAUSE_EN builds only)
//   crash           collision with car/wall, level
//   finish_line     collision with finish line, level
//   fuel_pickup     collision with fuel item, level
//   player_speed    current player speed, 0..512
//   game_state      0 IDLE,1 COUNTDOWN,2 RACING,3 CRASHED,4 FINISHED,
//                   5 GAME_OVER,6 PAUSED
//   player_enable   high only in RACING
//   countdown_digit digit shown during COUNTDOWN, else 0
//   lives           remaining lives
//   fuel            remaining fuel
//   distance        accumulated distance
//   win             high in FINISHED
//   game_over       high in GAME_OVER
//
// State table
//   state       | meaning
//   IDLE        | waiting for start key edge
//   COUNTDOWN   | 3-2-1 countdown, COUNTDOWN_STEP frames per digit
//   RACING      | player driving, distance/fuel accounting active
//   CRASHED     | crash animation, DEATH_FRAMES frames
//   FINISHED    | race won, waiting for start key edge
//   GAME_OVER   | lives or fuel exhausted, waiting for start key edge
//   PAUSED      | race frozen (PAUSE_EN builds only)

module race_sequencer #(
  parameter int          START_LIVES    = 3,
  parameter int          COUNTDOWN_STEP = 60,
  parameter int          DEATH_FRAMES   = 129,
  parameter int          FUEL_INIT      = 1000,
  parameter int          FUEL_STEP      = 30,
  parameter int          FUEL_BONUS     = 200,
  parameter logic [19:0] TRACK_LENGTH   = 20'd600000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       start_key,
`ifdef PAUSE_EN
  input  logic       pause_key,
`endif
  input  logic       crash,
  input  logic       finish_line,
  input  logic       fuel_pickup,
  input  logic [9:0] player_speed,
  output logic [2:0] game_state,
  output logic       player_enable,
  output logic [1:0] countdown_digit,
  output logic [1:0] lives,
  output logic [9:0] fuel,
  output logic [19:0] distance,
  output logic       win,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_RACING    = 3'd2,
    S_CRASHED   = 3'd3,
    S_FINISHED  = 3'd4,
    S_GAME_OVER = 3'd5,
    S_PAUSED    = 3'd6
  } state_t;

  localparam int TIMER_MAX = (COUNTDOWN_STEP > DEATH_FRAMES) ? COUNTDOWN_STEP : DEATH_FRAMES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam int BURN_W    = $clog2(FUEL_STEP + 1);

  // Timers count down from (period-1) to a terminal count of zero, which is
  // equivalent to an up-counter that wraps at period-1.
  localparam logic [TIMER_W-1:0] CD_LOAD    = TIMER_W'(COUNTDOWN_STEP - 1);
  localparam logic [TIMER_W-1:0] DEATH_LOAD = TIMER_W'(DEATH_FRAMES - 1);
  localparam logic [BURN_W-1:0]  BURN_LOAD  = BURN_W'(FUEL_STEP - 1);
  localparam logic [1:0]         LIVES_INIT = 2'(START_LIVES);
  localparam logic [9:0]         FUEL_LOAD  = 10'(FUEL_INIT);
  localparam logic [11:0]        BONUS      = 12'(FUEL_BONUS);

  state_t              state, state_next;
  logic                start_prev;
  logic                start_evt;
  logic [TIMER_W-1:0]  timer, timer_next;
  logic [BURN_W-1:0]   burn, burn_next;
  logic [1:0]          lives_next;
  logic [9:0]          fuel_next;
  logic [19:0]         dist_next;
  logic [1:0]          digit_next;

  // Racing datapath
  logic [20:0]         dist_sum;
  logic [19:0]         dist_sat;
  logic                moving;
  logic                fuel_dec;
  logic [BURN_W-1:0]   burn_adv;
  logic [11:0]         fuel_add;
  logic [11:0]         fuel_sub;
  logic [9:0]          fuel_clamped;

`ifdef PAUSE_EN
  logic                pause_prev;
  logic                pause_evt;
  assign pause_evt = pause_key & ~pause_prev;
`endif

  assign start_evt = start_key & ~start_prev;
  assign game_state = state;

  always_comb begin
    dist_sum = {1'b0, distance} + 21'(player_speed >> 4);
    dist_sat = (dist_sum >= {1'b0, TRACK_LENGTH}) ? TRACK_LENGTH : dist_sum[19:0];

    // Burn timer only runs while the car is moving.
    moving   = (player_speed != 10'd0);
    fuel_dec = 1'b0;
    burn_adv = burn;
    if (moving) begin
      if (burn == '0) begin
        burn_adv = BURN_LOAD;
        fuel_dec = 1'b1;
      end else begin
        burn_adv = burn - 1'b1;
      end
    end

    // Pickup and burn apply together; the sum is clamped to 0..1023.
    fuel_add = {2'b00, fuel} + (fuel_pickup ? BONUS : 12'd0);
    fuel_sub = (fuel_dec && (fuel_add != 12'd0)) ? fuel_add - 12'd1 : fuel_add;
    fuel_clamped = (fuel_sub > 12'd1023) ? 10'd1023 : fuel_sub[9:0];
  end

  always_comb begin
    state_next = state;
    timer_next = timer;
    burn_next  = burn;
    lives_next = lives;
    fuel_next  = fuel;
    dist_next  = distance;
    digit_next = countdown_digit;

    case (state)
      S_IDLE: begin
        if (start_evt) begin
          state_next = S_COUNTDOWN;
          lives_next = LIVES_INIT;
          fuel_next  = FUEL_LOAD;
          dist_next  = 20'd0;
          digit_next = 2'd3;
          timer_next = CD_LOAD;
          burn_next  = BURN_LOAD;
        end
      end

      S_COUNTDOWN: begin
        if (timer == '0) begin
          timer_next = CD_LOAD;
          if (countdown_digit > 2'd1) begin
            digit_next = countdown_digit - 2'd1;
          end else begin
            digit_next = 2'd0;
            burn_next  = BURN_LOAD;
            state_next = S_RACING;
          end
        end else begin
          timer_next = timer - 1'b1;
        end
      end

      S_RACING: begin
`ifdef PAUSE_EN
        if (pause_evt) begin
          state_next = S_PAUSED;
        end else
`endif
        if (crash) begin
          // Crash freezes distance and fuel on this frame.
          lives_next = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
          timer_next = DEATH_LOAD;
          state_next = S_CRASHED;
        end else begin
          dist_next = dist_sat;
          fuel_next = fuel_clamped;
          burn_next = burn_adv;
          if (finish_line || (dist_sat == TRACK_LENGTH)) begin
            state_next = S_FINISHED;
          end else if (fuel_clamped == 10'd0) begin
            state_next = S_GAME_OVER;
          end
        end
      end

      S_CRASHED: begin
        if (timer == '0) begin
          burn_next  = BURN_LOAD;
          state_next = (lives == 2'd0) ? S_GAME_OVER : S_RACING;
        end else begin
          timer_next = timer - 1'b1;
        end
      end

      S_FINISHED, S_GAME_OVER: begin
        if (start_evt) begin
          state_next = S_IDLE;
        end
      end

`ifdef PAUSE_EN
      S_PAUSED: begin
        if (pause_evt) begin
          state_next = S_RACING;
        end
      end
`endif

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      start_prev      <= 1'b0;
      timer           <= '0;
      burn            <= BURN_LOAD;
      lives           <= LIVES_INIT;
      fuel            <= FUEL_LOAD;
      distance        <= 20'd0;
      countdown_digit <= 2'd0;
      player_enable   <= 1'b0;
      win             <= 1'b0;
      game_over       <= 1'b0;
    end else if (frame_start) begin
      state           <= state_next;
      start_prev      <= start_key;
      timer           <= timer_next;
      burn            <= burn_next;
      lives           <= lives_next;
      fuel            <= fuel_next;
      distance        <= dist_next;
      countdown_digit <= digit_next;
      player_enable   <= (state_next == S_RACING);
      win             <= (state_next == S_FINISHED);
      game_over       <= (state_next == S_GAME_OVER);
    end
  end

`ifdef PAUSE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pause_prev <= 1'b0;
    end else if (frame_start) begin
      pause_prev <= pause_key;
    end
  end
`endif

endmodule

// File: tb/tb_race_sequencer.sv
module tb_race_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        start_key;
  logic        pause_key;
  logic        crash;
  logic        finish_line;
  logic        fuel_pickup;
  logic [9:0]  player_speed;
  logic [2:0]  game_state;
  logic        player_enable;
  logic [1:0]  countdown_digit;
  logic [1:0]  lives;
  logic [9:0]  fuel;
  logic [19:0] distance;
  logic        win;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  race_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .frame_start     (frame_start),
    .start_key       (start_key),
`ifdef PAUSE_EN
    .pause_key       (pause_key),
`endif
    .crash           (crash),
    .finish_line     (finish_line),
    .fuel_pickup     (fuel_pickup),
    .player_speed    (player_speed),
    .game_state      (game_state),
    .player_enable   (player_enable),
    .countdown_digit (countdown_digit),
    .lives           (lives),
    .fuel            (fuel),
    .distance        (distance),
    .win             (win),
    .game_over       (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic frame();
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic idle_cycle();
    frame_start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Release then press start on consecutive frames.
  task automatic press_start();
    start_key = 1'b0;
    frame();
    start_key = 1'b1;
    frame();
    start_key = 1'b0;
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; start_key = 1'b0; pause_key = 1'b0;
    crash = 1'b0; finish_line = 1'b0; fuel_pickup = 1'b0; player_speed = 10'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    chk("rst_state", game_state, 0);
    chk("rst_lives", lives, 3);
    chk("rst_fuel", fuel, 1000);
    chk("rst_dist", distance, 0);
    chk("rst_enable", player_enable, 0);
    chk("rst_digit", countdown_digit, 0);
    chk("rst_win", win, 0);
    chk("rst_gameover", game_over, 0);

    // Start key without a frame pulse must not move the FSM.
    start_key = 1'b1;
    idle_cycle();
    chk("no_frame_hold", game_state, 0);
    frame();
    start_key = 1'b0;
    chk("cd_state", game_state, 1);
    chk("cd_digit3", countdown_digit, 3);
    frames(59);
    chk("cd_digit3_end", countdown_digit, 3);
    frame();
    chk("cd_digit2", countdown_digit, 2);
    frames(60);
    chk("cd_digit1", countdown_digit, 1);
    frames(59);
    chk("cd_last_state", game_state, 1);
    player_speed = 10'd512;
    frame();
    chk("race_state", game_state, 2);
    chk("race_enable", player_enable, 1);
    chk("race_digit0", countdown_digit, 0);

    frames(10);
    chk("dist_10", distance, 320);
    chk("fuel_10", fuel, 1000);
    idle_cycle();
    idle_cycle();
    chk("dist_noframe", distance, 320);
    frames(20);
    chk("fuel_30", fuel, 999);
    chk("dist_30", distance, 960);
    frames(30);
    chk("fuel_60", fuel, 998);
    chk("dist_60", distance, 1920);
    player_speed = 10'd0;
    frames(60);
    chk("fuel_stopped", fuel, 998);
    chk("dist_stopped", distance, 1920);

    // crash beats finish on the same frame
    player_speed = 10'd512;
    crash = 1'b1; finish_line = 1'b1;
    frame();
    crash = 1'b0; finish_line = 1'b0;
    chk("crash_state", game_state, 3);
    chk("crash_lives", lives, 2);
    chk("crash_dist", distance, 1920);
    chk("crash_fuel", fuel, 998);
    chk("crash_enable", player_enable, 0);
    frames(128);
    chk("crash_hold", game_state, 3);
    frame();
    chk("recover_state", game_state, 2);
    chk("recover_enable", player_enable, 1);
    chk("recover_dist", distance, 1920);

    player_speed = 10'd0;
    fuel_pickup = 1'b1;
    frame();
    fuel_pickup = 1'b0;
    chk("pickup_clamp", fuel, 1023);

    // start press during RACING is ignored, and stays held into FINISHED
    start_key = 1'b1;
    frame();
    chk("start_in_race", game_state, 2);
    player_speed = 10'd16;
    finish_line = 1'b1;
    frame();
    finish_line = 1'b0;
    chk("finish_state", game_state, 4);
    chk("finish_win", win, 1);
    chk("finish_dist", distance, 1921);
    chk("finish_enable", player_enable, 0);
    frames(3);
    chk("held_start", game_state, 4);
    start_key = 1'b0;
    frame();
    chk("release_start", game_state, 4);
    start_key = 1'b1;
    frame();
    chk("repress_idle", game_state, 0);
    chk("idle_win", win, 0);

    // Game 2: fuel runs down to 1, pickup on the burn frame, then empty.
    press_start();
    chk("g2_cd", game_state, 1);
    chk("g2_lives", lives, 3);
    chk("g2_fuel", fuel, 1000);
    chk("g2_dist", distance, 0);
    player_speed = 10'd16;
    frames(180);
    chk("g2_race", game_state, 2);
    frames(29970);
    chk("g2_fuel1", fuel, 1);
    chk("g2_dist1", distance, 29970);
    frames(29);
    chk("g2_fuel1_hold", fuel, 1);
    fuel_pickup = 1'b1;
    frame();
    fuel_pickup = 1'b0;
    chk("g2_pickup_burn", fuel, 200);
    chk("g2_state_pick", game_state, 2);
    frames(5999);
    chk("g2_fuel_last", fuel, 1);
    chk("g2_state_last", game_state, 2);
    frame();
    chk("g2_fuel_empty", fuel, 0);
    chk("g2_gameover_state", game_state, 5);
    chk("g2_gameover_flag", game_over, 1);
    chk("g2_dist_exit", distance, 36000);
    chk("g2_enable", player_enable, 0);

    // Game 3: drive to the track length, with saturation on the last step.
    start_key = 1'b1;
    frame();
    chk("g3_idle", game_state, 0);
    chk("g3_idle_go", game_over, 0);
    press_start();
    chk("g3_cd", game_state, 1);
    player_speed = 10'd512;
    frames(180);
    chk("g3_race", game_state, 2);
    frames(5);
    chk("g3_dist5", distance, 160);
`ifdef PAUSE_EN
    pause_key = 1'b1;
    frame();
    pause_key = 1'b0;
    chk("pause_state", game_state, 6);
    chk("pause_enable", player_enable, 0);
    crash = 1'b1;
    frames(100);
    crash = 1'b0;
    chk("pause_dist", distance, 160);
    chk("pause_fuel", fuel, 1000);
    chk("pause_lives", lives, 3);
    chk("pause_hold", game_state, 6);
    pause_key = 1'b1;
    frame();
    pause_key = 1'b0;
    chk("resume_state", game_state, 2);
    chk("resume_dist", distance, 160);
`endif
    player_speed = 10'd48;
    frame();
    chk("g3_dist163", distance, 163);
    player_speed = 10'd512;
    frames(18744);
    chk("g3_dist_near", distance, 599971);
    chk("g3_state_near", game_state, 2);
    frame();
    chk("g3_dist_sat", distance, 600000);
    chk("g3_finish", game_state, 4);
    chk("g3_win", win, 1);

    // Game 4: three crashes end the game after the last crash animation.
    start_key = 1'b1;
    frame();
    press_start();
    chk("g4_cd", game_state, 1);
    frames(180);
    crash = 1'b1; frame(); crash = 1'b0;
    chk("g4_lives2", lives, 2);
    frames(129);
    crash = 1'b1; frame(); crash = 1'b0;
    chk("g4_lives1", lives, 1);
    frames(129);
    chk("g4_race2", game_state, 2);
    crash = 1'b1; frame(); crash = 1'b0;
    chk("g4_lives0", lives, 0);
    chk("g4_crash3", game_state, 3);
    frames(128);
    chk("g4_crash3_hold", game_state, 3);
    frame();
    chk("g4_gameover", game_state, 5);
    chk("g4_gameover_flag", game_over, 1);

    // Game 5: reset in the middle of a crash.
    start_key = 1'b1;
    frame();
    press_start();
    player_speed = 10'd512;
    frames(180);
    frames(10);
    chk("g5_dist", distance, 320);
    crash = 1'b1; frame(); crash = 1'b0;
    chk("g5_crash", game_state, 3);
    frames(50);
    reset = 1'b1;
    frame();
    reset = 1'b0;
    chk("g5_rst_state", game_state, 0);
    chk("g5_rst_lives", lives, 3);
    chk("g5_rst_fuel", fuel, 1000);
    chk("g5_rst_dist", distance, 0);
    chk("g5_rst_enable", player_enable, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/race_sequencer.md
Name: race_sequencer

Overview:
Frame-rate game sequencer that drives the player controller and HUD. It runs the race flow: idle, start countdown, racing, crash recovery, finish and game over. It also owns lives, fuel and distance travelled. It sits between keyboard/collision logic and the player controller, gating the controller with player_enable.

Parameters:
START_LIVES, 3, lives loaded at game start (1..3)
COUNTDOWN_STEP, 60, frames per countdown digit
DEATH_FRAMES, 129, frames spent in CRASHED (matches crash animation length)
FUEL_INIT, 1000, fuel loaded at game start (<=1023)
FUEL_STEP, 30, frames per 1-unit fuel burn while moving
FUEL_BONUS, 200, fuel added per pickup
TRACK_LENGTH, 20'd600000, distance at which race auto-finishes

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
frame_start  in  1  one-cycle pulse per video frame; all state advances only on these cycles
start_key  in  1  start/restart key level
crash  in  1  player-vs-car/wall collision level (sampled on frame_start)
finish_line  in  1  player-vs-finish-line collision level
fuel_pickup  in  1  player-vs-fuel-item collision level
player_speed  in  10  current player speed, 0..512
game_state  out  3  0 IDLE,1 COUNTDOWN,2 RACING,3 CRASHED,4 FINISHED,5 GAME_OVER,6 PAUSED
player_enable  out  1  1 only in RACING; player controller ignores keys when 0
countdown_digit  out  2  digit shown during COUNTDOWN, else 0
lives  out  2  remaining lives
fuel  out  10  remaining fuel
distance  out  20  accumulated distance
win  out  1  1 in FINISHED
game_over  out  1  1 in GAME_OVER

Behaviour:
- Reset (synchronous, wins over frame_start): state IDLE. All outputs 0 except lives=START_LIVES and fuel=FUEL_INIT. Frame counter 0, start_key history 0.
- All outputs are registered. They change on the clk edge that samples frame_start=1. No change on other cycles.
- start_key edge: start_evt = start_key & ~start_prev. start_prev updates on frame_start cycles only.
- IDLE: on start_evt -> COUNTDOWN. Load lives=START_LIVES, fuel=FUEL_INIT, distance=0, countdown_digit=3, counter=0.
- COUNTDOWN: counter+1 per frame. At counter==COUNTDOWN_STEP-1: reset counter; if digit>1, digit-1; if digit==1, digit=0 and -> RACING. Total 3*COUNTDOWN_STEP frames. Collision inputs ignored.
- RACING: player_enable=1.
  - distance += player_speed>>4, saturating at TRACK_LENGTH.
  - Burn counter advances only when player_speed!=0. At FUEL_STEP-1 it wraps and fuel_dec=1.
  - fuel_next = clamp(fuel + (fuel_pickup?FUEL_BONUS:0) - fuel_dec, 0, 1023). Pickup and burn in the same frame both apply.
  - Exit priority in the same frame: crash > finish > fuel empty.
    - crash: lives-1 (saturate 0), counter=0 -> CRASHED.
    - finish_line=1, or distance_next==TRACK_LENGTH -> FINISHED.
    - fuel_next==0 -> GAME_OVER.
  - Distance and fuel still update on the exit frame, except on crash, which freezes both.
- CRASHED: player_enable=0. Collisions ignored; counter+1. At counter==DEATH_FRAMES-1: lives==0 -> GAME_OVER, else -> RACING with no countdown. Fuel/distance preserved, burn counter cleared.
- FINISHED: win=1, player_enable=0. start_evt -> IDLE.
- GAME_OVER: game_over=1. start_evt -> IDLE.
- start_key held continuously through FINISHED/GAME_OVER does not restart; a release and re-press is required.
- game_state 6 is unused unless PAUSE_EN is defined.

Optional Feature:
PAUSE_EN:
- Adds input port pause_key (1 bit), edge-detected exactly like start_key.
- In RACING, a pause edge -> PAUSED (state 6, player_enable=0, all counters, fuel and distance frozen, collisions ignored).
- In PAUSED, a pause edge -> RACING with counters resumed unchanged.
- Pause edges are ignored in other states. Reset in PAUSED -> IDLE.
- Without the macro: no port, no PAUSED state, game_state never 6.

Test Plan:
- Reset, then start_key pulse on a frame -> COUNTDOWN, digit 3. Digit is 2 after 60 frames, 1 after 120. RACING with player_enable=1 on frame 180.
- RACING, speed 512 for 10 frames -> distance 320. fuel==999 at frame 30, 998 at frame 60. Speed 0 for 60 frames -> fuel unchanged.
- crash=1 with lives=3 -> CRASHED, lives 2, player_enable 0 for 129 frames, then RACING with distance unchanged. Third crash -> GAME_OVER after 129 frames.
- crash and finish_line asserted on the same frame -> CRASHED, not FINISHED. finish_line alone -> FINISHED, win=1. Held start_key ignored; release+press -> IDLE.
- fuel=1, burn wrap and fuel_pickup on the same frame -> fuel 200. fuel=1, burn wrap, no pickup -> fuel 0 and GAME_OVER.
- reset asserted mid-CRASHED on a frame_start cycle -> IDLE, lives 3, fuel 1000, distance 0 on the next edge. PAUSE_EN build: pause in RACING freezes distance/fuel 100 frames, second pause resumes.
